// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational grant selection between the I-cache and D-cache requesters.
// MEM_ARB_ROUND_ROBIN_EN: alternate on ties instead of fixed DC-over-IC priority.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic    ic_req,
    input  logic    dc_req,
    input  req_id_t last_id,
    output req_id_t grant_id,
    output logic    grant_valid
);

    assign grant_valid = ic_req | dc_req;

    // NOTE: grant_id is given a default first so no path through the block infers a latch.
    always_comb begin
        grant_id = REQ_IC;
        if (ic_req && dc_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_id = (last_id == REQ_IC) ? REQ_DC : REQ_IC;
`else
            grant_id = REQ_DC;
`endif
        end else if (dc_req) begin
            grant_id = REQ_DC;
        end
    end

`ifndef MEM_ARB_ROUND_ROBIN_EN
    logic w_last_id_unused;
    assign w_last_id_unused = last_id;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache reads and D-cache reads/writes onto one line-wide memory port.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default: DC has priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [LINE_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_write_data,
    input  logic [LINE_W-1:0] mem_read_data,
    input  logic              mem_ready
);

    state_t                     r_state;
    state_t                     w_state_nxt;
    req_id_t                    r_owner;
    req_id_t                    w_grant_id;
    logic                       w_grant_valid;
    logic                       r_we;
    logic [ADDR_W-OFFSET_W-1:0] r_line;
    logic [LINE_W-1:0]          r_wdata;
    logic                       r_ic_ready;
    logic                       r_dc_ready;
    logic [LINE_W-1:0]          r_ic_rdata;
    logic [LINE_W-1:0]          r_dc_rdata;

    // The owner of the last grant doubles as the round-robin history.
    mem_arb_picker u_picker (
        .ic_req      (ic_req),
        .dc_req      (dc_req),
        .last_id     (r_owner),
        .grant_id    (w_grant_id),
        .grant_valid (w_grant_valid)
    );

    always_comb begin
        w_state_nxt  = r_state;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        case (r_state)
            IDLE:  if (w_grant_valid) w_state_nxt = ISSUE;
            ISSUE: begin
                mem_read_en  = ~r_we;
                mem_write_en = r_we;
                w_state_nxt  = WAIT;
            end
            WAIT:  if (mem_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= REQ_IC;
            r_we       <= 1'b0;
            r_line     <= '0;
            r_wdata    <= '0;
            r_ic_ready <= 1'b0;
            r_dc_ready <= 1'b0;
            r_ic_rdata <= '0;
            r_dc_rdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ic_ready <= 1'b0;
            r_dc_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner <= w_grant_id;
                        if (w_grant_id == REQ_DC) begin
                            r_we    <= dc_we;
                            r_line  <= dc_addr[ADDR_W-1:OFFSET_W];
                            r_wdata <= dc_wdata;
                        end else begin
                            r_we    <= 1'b0;
                            r_line  <= ic_addr[ADDR_W-1:OFFSET_W];
                            r_wdata <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        if (r_owner == REQ_IC) begin
                            r_ic_ready <= 1'b1;
                            r_ic_rdata <= mem_read_data;
                        end else begin
                            r_dc_ready <= 1'b1;
                            if (!r_we) r_dc_rdata <= mem_read_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr       = {r_line, {OFFSET_W{1'b0}}};
    assign mem_write_data = r_wdata;
    assign ic_ready       = r_ic_ready;
    assign dc_ready       = r_dc_ready;
    assign ic_rdata       = r_ic_rdata;
    assign dc_rdata       = r_dc_rdata;

    // Byte offsets within a line never reach memory.
    logic w_offset_unused;
    assign w_offset_unused = ^{ic_addr[OFFSET_W-1:0], dc_addr[OFFSET_W-1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
    logic [31:0]  ic_addr = '0, dc_addr = '0;
    logic [127:0] dc_wdata = '0;
    logic [127:0] ic_rdata, dc_rdata;
    logic         ic_ready, dc_ready;
    logic         mem_read_en, mem_write_en;
    logic [31:0]  mem_addr;
    logic [127:0] mem_write_data;
    logic [127:0] mem_read_data = '0;
    logic         mem_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ready(dc_ready),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_ready(mem_ready)
    );

    // ---------------- backing-memory environment ----------------
    typedef struct packed {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] data;
    } issue_t;

    issue_t       issue_log[$];
    logic [127:0] env_mem [logic [31:0]];
    int           mem_lat = 1;
    bit           force_issue_ready = 1'b0;
    int           env_cnt = 0;
    bit           prev_en = 1'b0;
    logic [31:0]  cap_addr = '0;
    logic [127:0] cap_data = '0;

    function automatic logic [127:0] line_init(input logic [31:0] a);
        return {a ^ 32'h5A5A_0001, ~a, a + 32'h1357_9BDF, {a[15:0], a[31:16]}};
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            env_cnt   = 0;
            mem_ready = 1'b0;
            prev_en   = 1'b0;
        end else begin
            mem_ready = 1'b0;
            if (mem_read_en || mem_write_en) begin
                checks++;
                if (mem_read_en && mem_write_en) begin
                    failures++; $display("FAIL both_enables: got rd=%b wr=%b expected one", mem_read_en, mem_write_en);
                end
                checks++;
                if (prev_en) begin
                    failures++; $display("FAIL enable_width: got enable high 2 cycles expected 1");
                end
                checks++;
                if (mem_addr[3:0] !== 4'h0) begin
                    failures++; $display("FAIL addr_align: got %h expected line-aligned", mem_addr);
                end
                issue_log.push_back('{we: mem_write_en, addr: mem_addr, data: mem_write_data});
                if (mem_write_en) env_mem[mem_addr] = mem_write_data;
                cap_addr = mem_addr;
                cap_data = mem_write_data;
                env_cnt  = mem_lat;
                if (force_issue_ready) begin
                    mem_ready     = 1'b1;
                    mem_read_data = {4{32'hBAD0_BAD0}};
                end
            end else if (env_cnt > 0) begin
                checks++;
                if (mem_addr !== cap_addr || mem_write_data !== cap_data) begin
                    failures++;
                    $display("FAIL hold_stable: got addr=%h data=%h expected addr=%h data=%h", mem_addr, mem_write_data, cap_addr, cap_data);
                end
                env_cnt--;
                if (env_cnt == 0) begin
                    mem_ready     = 1'b1;
                    mem_read_data = env_mem.exists(cap_addr) ? env_mem[cap_addr] : line_init(cap_addr);
                end
            end
            prev_en = mem_read_en || mem_write_en;
        end
    end

    // ---------------- reference model ----------------
    logic [127:0] model_mem [logic [31:0]];
    logic [127:0] exp_ic_rdata = '0;
    logic [127:0] exp_dc_rdata = '0;
    bit           last_dc = 1'b0;

    function automatic bit model_pick_dc(input bit ic, input bit dc);
        if (!dc) return 1'b0;
        if (!ic) return 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return !last_dc;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [127:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : line_init(a);
    endfunction

    task automatic model_reset();
        exp_ic_rdata = '0;
        exp_dc_rdata = '0;
        last_dc      = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        issue_log.delete();
    endtask

    // One request round: drive the chosen requesters, collect ready pulses, compare against the model.
    task automatic run_round(input string name, input bit do_ic, input logic [31:0] ia,
                             input bit do_dc, input bit we, input logic [31:0] da,
                             input logic [127:0] wd, input int lat, input int drop_at);
        bit           first_dc;
        int           n_ic, n_dc, p_ic, p_dc, exp_n_ic, exp_n_dc;
        logic [31:0]  il, dl;
        issue_t       exp_q[$];
        issue_t       e;
        il = {ia[31:4], 4'h0};
        dl = {da[31:4], 4'h0};
        mem_lat = lat;
        issue_log.delete();
        n_ic = 0; n_dc = 0; p_ic = 0; p_dc = 0;
        @(negedge clk);
        ic_req = do_ic; ic_addr = ia;
        dc_req = do_dc; dc_addr = da; dc_wdata = wd;
        dc_we  = do_dc ? we : 1'($urandom_range(0, 1));
        first_dc = model_pick_dc(do_ic, do_dc);
        for (int c = 1; c <= 8 * lat + 20 && !((p_ic > 0 || !do_ic) && (p_dc > 0 || !do_dc)); c++) begin
            @(negedge clk);
            if (c == drop_at) begin ic_req = 1'b0; dc_req = 1'b0; end
            if (ic_ready) begin p_ic++; if (n_ic == 0) n_ic = c; ic_req = 1'b0; end
            if (dc_ready) begin p_dc++; if (n_dc == 0) n_dc = c; dc_req = 1'b0; end
        end
        ic_req = 1'b0; dc_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ic_ready) p_ic++;
            if (dc_ready) p_dc++;
        end
        // Model: winner ready after lat+2 cycles, loser granted on the following edge.
        if (do_ic && do_dc) begin
            exp_n_ic = first_dc ? 2 * lat + 4 : lat + 2;
            exp_n_dc = first_dc ? lat + 2 : 2 * lat + 4;
        end else begin
            exp_n_ic = lat + 2;
            exp_n_dc = lat + 2;
        end
        checks++;
        if (p_ic !== int'(do_ic)) begin
            failures++; $display("FAIL %s ic_ready_pulses: got %0d expected %0d", name, p_ic, int'(do_ic));
        end
        checks++;
        if (p_dc !== int'(do_dc)) begin
            failures++; $display("FAIL %s dc_ready_pulses: got %0d expected %0d", name, p_dc, int'(do_dc));
        end
        if (do_ic) begin
            checks++;
            if (n_ic !== exp_n_ic) begin
                failures++; $display("FAIL %s ic_latency: got %0d expected %0d", name, n_ic, exp_n_ic);
            end
        end
        if (do_dc) begin
            checks++;
            if (n_dc !== exp_n_dc) begin
                failures++; $display("FAIL %s dc_latency: got %0d expected %0d", name, n_dc, exp_n_dc);
            end
        end
        // Expected memory traffic and model update, in service order.
        for (int k = 0; k < 2; k++) begin
            bit serve_dc;
            serve_dc = (k == 0) ? first_dc : !first_dc;
            if (serve_dc && do_dc) begin
                exp_q.push_back('{we: we, addr: dl, data: wd});
                if (we) model_mem[dl] = wd;
                else exp_dc_rdata = model_read(dl);
                last_dc = 1'b1;
            end else if (!serve_dc && do_ic) begin
                exp_q.push_back('{we: 1'b0, addr: il, data: '0});
                exp_ic_rdata = model_read(il);
                last_dc = 1'b0;
            end
        end
        checks++;
        if (issue_log.size() !== exp_q.size()) begin
            failures++; $display("FAIL %s issue_count: got %0d expected %0d", name, issue_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                e = issue_log[k];
                checks++;
                if (e.we !== exp_q[k].we || e.addr !== exp_q[k].addr || (e.we && e.data !== exp_q[k].data)) begin
                    failures++;
                    $display("FAIL %s issue%0d: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                             name, k, e.we, e.addr, e.data, exp_q[k].we, exp_q[k].addr, exp_q[k].data);
                end
            end
        end
        checks++;
        if (ic_rdata !== exp_ic_rdata) begin
            failures++; $display("FAIL %s ic_rdata: got %h expected %h", name, ic_rdata, exp_ic_rdata);
        end
        checks++;
        if (dc_rdata !== exp_dc_rdata) begin
            failures++; $display("FAIL %s dc_rdata: got %h expected %h", name, dc_rdata, exp_dc_rdata);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_read_en, mem_write_en, mem_addr, mem_write_data, ic_rdata, dc_rdata, ic_ready, dc_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%h ic_rdata=%h dc_rdata=%h rd=%b wr=%b expected all 0",
                     mem_addr, ic_rdata, dc_rdata, mem_read_en, mem_write_en);
        end
        reset = 1'b0;
        model_reset();
        issue_log.delete();
        repeat (4) @(negedge clk);
        checks++;
        if (issue_log.size() !== 0 || ic_ready !== 1'b0 || dc_ready !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: got %0d issues expected 0", issue_log.size());
        end
    endtask

    task automatic test_ic_read();
        run_round("ic_read", 1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0, '0, 1, 0);
    endtask

    task automatic test_dc_write();
        run_round("dc_read_pre", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0080, '0, 2, 0);
        run_round("dc_write", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0040,
                  128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C, 3, 0);
        run_round("dc_readback", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0048, '0, 1, 0);
    endtask

    task automatic test_priority();
        apply_reset();
        run_round("same_cycle", 1'b1, 32'h0000_2010, 1'b1, 1'b0, 32'h0000_2020, '0, 2, 0);
    endtask

    task automatic test_back_to_back_hold();
        bit           seq[3];
        int           pulses;
        logic [31:0]  a_ic, a_dc;
        apply_reset();
        a_ic = 32'h0000_4000;
        a_dc = 32'h0000_3000;
        mem_lat = 1;
        pulses = 0;
        @(negedge clk);
        ic_req = 1'b1; ic_addr = a_ic; dc_req = 1'b1; dc_we = 1'b0; dc_addr = a_dc;
        for (int c = 0; c < 60 && pulses < 3; c++) begin
            @(negedge clk);
            if (ic_ready || dc_ready) pulses++;
            if (pulses == 3) begin ic_req = 1'b0; dc_req = 1'b0; end
        end
        ic_req = 1'b0; dc_req = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            seq[k] = model_pick_dc(1'b1, 1'b1);
            last_dc = seq[k];
            if (seq[k]) exp_dc_rdata = model_read(a_dc);
            else exp_ic_rdata = model_read(a_ic);
        end
        checks++;
        if (issue_log.size() !== 3) begin
            failures++; $display("FAIL hold_grants: got %0d grants expected 3", issue_log.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (issue_log[k].addr !== (seq[k] ? a_dc : a_ic)) begin
                    failures++; $display("FAIL hold_order%0d: got addr %h expected %h", k, issue_log[k].addr, seq[k] ? a_dc : a_ic);
                end
            end
        end
        checks++;
        if (ic_rdata !== exp_ic_rdata || dc_rdata !== exp_dc_rdata) begin
            failures++; $display("FAIL hold_rdata: got ic=%h dc=%h expected ic=%h dc=%h", ic_rdata, dc_rdata, exp_ic_rdata, exp_dc_rdata);
        end
    endtask

    task automatic test_reset_in_wait();
        int pulses;
        run_round("pre_reset", 1'b1, 32'h0000_5004, 1'b0, 1'b0, 32'h0, '0, 1, 0);
        mem_lat = 6;
        @(negedge clk);
        ic_req = 1'b1; ic_addr = 32'h0000_2008;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_addr !== 32'h0000_2000) begin
            failures++; $display("FAIL wait_addr: got %h expected %h", mem_addr, 32'h0000_2000);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_read_en, mem_write_en, mem_addr, mem_write_data, ic_rdata, dc_rdata, ic_ready, dc_ready} !== '0) begin
            failures++; $display("FAIL reset_in_wait: got addr=%h ic_rdata=%h expected all 0", mem_addr, ic_rdata);
        end
        ic_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (ic_ready || dc_ready) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++; $display("FAIL dropped_txn_ready: got %0d pulses expected 0", pulses);
        end
        run_round("after_reset", 1'b1, 32'h0000_2008, 1'b0, 1'b0, 32'h0, '0, 2, 0);
    endtask

    task automatic test_early_mem_ready();
        force_issue_ready = 1'b1;
        run_round("early_ready", 1'b1, 32'h0000_6abc, 1'b0, 1'b0, 32'h0, '0, 3, 0);
        force_issue_ready = 1'b0;
    endtask

    task automatic test_drop_req();
        run_round("drop_ic", 1'b1, 32'h0000_7070, 1'b0, 1'b0, 32'h0, '0, 3, 2);
        run_round("drop_dc", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_7070, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2, 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int           kind;
            logic [31:0]  ia, da;
            logic [127:0] wd;
            kind = $urandom_range(0, 2);
            ia   = 32'h0000_1000 + 32'($urandom_range(0, 63));
            da   = 32'h0000_1000 + 32'($urandom_range(0, 63));
            wd   = {$urandom, $urandom, $urandom, $urandom};
            run_round("random", kind != 1, ia, kind != 0, 1'($urandom_range(0, 1)), da, wd,
                      $urandom_range(1, 4), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ic_read();
        test_dc_write();
        test_priority();
        test_back_to_back_hold();
        test_reset_in_wait();
        test_early_mem_ready();
        test_drop_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter LINE_W, default 128, line width in bits (16 bytes).
REQ-003 SHALL have port clk, input, 1, single clock; all state on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have ports ic_req in 1, ic_addr in ADDR_W, ic_rdata out LINE_W and ic_ready out 1, forming the instruction-cache read-only requester.
REQ-006 SHALL have ports dc_req in 1, dc_we in 1, dc_addr in ADDR_W, dc_wdata in LINE_W, dc_rdata out LINE_W and dc_ready out 1, forming the data-cache read/write requester.
REQ-007 SHALL have ports mem_read_en out 1, mem_write_en out 1, mem_addr out ADDR_W, mem_write_data out LINE_W, mem_read_data in LINE_W and mem_ready in 1, connecting to the backing memory.

Function
REQ-008 SHALL implement states IDLE, ISSUE and WAIT.
REQ-009 SHALL, in IDLE with any req high, grant one requester and latch its id, op (read/write), address and write data, then go to ISSUE.
REQ-010 SHALL drive mem_addr = {latched_addr[ADDR_W-1:4], 4'b0}, which is line-aligned.
REQ-011 SHALL assert mem_read_en or mem_write_en for exactly one cycle, in ISSUE, then go to WAIT; both enables are never high together.
REQ-012 SHALL hold mem_addr and mem_write_data stable from ISSUE until the cycle mem_ready is seen.
REQ-013 SHALL, in WAIT on mem_ready=1, pulse the owner's *_ready for one cycle, register mem_read_data into the owner's *_rdata on a read, and return to IDLE.
REQ-014 SHALL leave the non-owner's ready and rdata unchanged, and leave dc_rdata unchanged on a write.
REQ-015 SHALL ignore mem_ready in IDLE and ISSUE.
REQ-016 SHALL require requesters to hold req and payload until their ready pulse; a req dropped after grant still completes and still pulses ready.
REQ-017 SHALL spend one IDLE cycle between transactions, so back-to-back grants are at least one cycle apart after ready.
REQ-018 SHALL make request-to-ready latency equal to memory latency + 2 cycles.
REQ-019 SHALL ignore dc_we when dc_req is low.

Reset
REQ-020 SHALL, on reset, force state=IDLE, drop any in-flight transaction without a ready pulse, and clear all outputs and latched fields to 0.
REQ-021 SHALL grant nothing in the first cycle after reset deassertion unless req is high at that edge.

Configuration
REQ-022 SHALL, without MEM_ARB_ROUND_ROBIN_EN, use fixed priority: dc_req beats ic_req.
REQ-023 SHALL, with MEM_ARB_ROUND_ROBIN_EN, grant the requester not served last when both are requesting; last-served resets to IC, so DC wins the first tie.

Structure
REQ-024 SHALL place the state typedef (IDLE/ISSUE/WAIT), the requester-id typedef (REQ_IC/REQ_DC) and the LINE_BYTES=16 constant in package mem_arb_pkg.
REQ-025 SHALL implement grant selection in sub-module mem_arb_picker (inputs ic_req, dc_req, last_id; output grant_id and grant_valid), which is purely combinational.

Verification
REQ-026 SHALL cover: ic_req with ic_addr=0x0000_1234 -> one-cycle mem_read_en, mem_addr=0x0000_1230, ic_ready pulse, ic_rdata=mem_read_data.
REQ-027 SHALL cover: dc_req with dc_we=1, dc_addr=0x40 and dc_wdata=0xDEADBEEF_... -> one-cycle mem_write_en, data stable until mem_ready, dc_ready pulse, dc_rdata unchanged.
REQ-028 SHALL cover: ic_req and dc_req rising in the same cycle, fixed priority -> DC served first, then IC; with round-robin and both held across three grants -> DC, IC, DC.
REQ-029 SHALL cover: reset asserted in WAIT -> outputs 0 in the same cycle, no ready pulse, next request served normally.
REQ-030 SHALL cover: mem_ready forced high in ISSUE -> ignored, no ready pulse until a real mem_ready arrives in WAIT.
REQ-031 SHALL cover: requester drops req in WAIT -> transaction completes and the ready pulse is still issued.
